flp_accum: RTL and testbench

//  Streaming floating point accumulator: sums a vector of FP operands

---
 rtl/flp_accum.sv | 165 ++++++++++++++++
 tb/tb_flp_accum.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/flp_accum.sv
// Streaming floating point accumulator: folds a valid/ready operand stream into one
// sum per vector through a single combinational adder, with registered state.

module flp_add_test #(
  parameter int EWIDTH  = 8,
  parameter int SWIDTH  = 23,
  parameter int RSWIDTH = 2
) (
  input  logic [EWIDTH+SWIDTH:0] a,
  input  logic [EWIDTH+SWIDTH:0] b,
  output logic [EWIDTH+SWIDTH:0] y
);
  localparam int FWIDTH = 1 + EWIDTH + SWIDTH;
  // hidden bit + stored significand + rounding bits + sticky bit
  localparam int MW = SWIDTH + RSWIDTH + 2;
  localparam logic [EWIDTH-1:0] EMAX = '1;
  localparam logic signed [EWIDTH+1:0] EONE  = 1;
  localparam logic signed [EWIDTH+1:0] EZERO = '0;
  localparam logic signed [EWIDTH+1:0] EINF  = signed'({2'b00, EMAX});
  localparam logic [FWIDTH-1:0] QNAN = {1'b0, EMAX, 1'b1, {(SWIDTH-1){1'b0}}};

  logic              sa, sb, sl, ss, swap, found, guard, rest, up;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [EWIDTH-1:0] ea, eb, el, es, diff;
  logic [SWIDTH-1:0] fa, fb, fl, fs, frac;
  logic [MW-1:0]     ml, ms, norm;
  logic [2*MW-1:0]   wide;
  logic [MW:0]       sum;
  logic [EWIDTH+1:0] lz;
  logic signed [EWIDTH+1:0] ex;
  logic [SWIDTH:0]   mant;
  logic [SWIDTH+1:0] mant_r;

  always_comb begin
    sa = a[FWIDTH-1]; ea = a[FWIDTH-2:SWIDTH]; fa = a[SWIDTH-1:0];
    sb = b[FWIDTH-1]; eb = b[FWIDTH-2:SWIDTH]; fb = b[SWIDTH-1:0];
    a_nan  = (ea == EMAX) && (fa != '0);
    b_nan  = (eb == EMAX) && (fb != '0);
    a_inf  = (ea == EMAX) && (fa == '0);
    b_inf  = (eb == EMAX) && (fb == '0);
    a_zero = (ea == '0);
    b_zero = (eb == '0);

    // Order operands by magnitude so the subtraction never goes negative.
    swap = {eb, fb} > {ea, fa};
    sl = swap ? sb : sa;  el = swap ? eb : ea;  fl = swap ? fb : fa;
    ss = swap ? sa : sb;  es = swap ? ea : eb;  fs = swap ? fa : fb;
    diff = el - es;

    ml   = {1'b1, fl, {(RSWIDTH+1){1'b0}}};
    wide = {1'b1, fs, {(RSWIDTH+1){1'b0}}, {MW{1'b0}}} >> diff;
    if (int'(diff) >= MW) ms = {{(MW-1){1'b0}}, 1'b1};
    else                  ms = wide[2*MW-1:MW] | {{(MW-1){1'b0}}, |wide[MW-1:0]};

    sum = (sl == ss) ? ({1'b0, ml} + {1'b0, ms}) : ({1'b0, ml} - {1'b0, ms});

    lz = '0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found && sum[i]) begin
        found = 1'b1;
        lz = (EWIDTH+2)'(MW - 1 - i);
      end
    end

    ex = signed'({2'b00, el});
    if (sum[MW]) begin
      norm = sum[MW:1] | {{(MW-1){1'b0}}, sum[0]};
      ex = ex + EONE;
    end else begin
      norm = sum[MW-1:0] << lz;
      ex = ex - signed'(lz);
    end

    // Round to nearest, ties to even.
    mant   = norm[MW-1:RSWIDTH+1];
    guard  = norm[RSWIDTH];
    rest   = |norm[RSWIDTH-1:0];
    up     = guard & (rest | mant[0]);
    mant_r = {1'b0, mant} + {{(SWIDTH+1){1'b0}}, up};
    if (mant_r[SWIDTH+1]) begin
      ex = ex + EONE;
      frac = mant_r[SWIDTH:1];
    end else begin
      frac = mant_r[SWIDTH-1:0];
    end

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) y = QNAN;
    else if (a_inf)                     y = a;
    else if (b_inf)                     y = b;
    else if (a_zero && b_zero)          y = '0;
    else if (a_zero)                    y = b;
    else if (b_zero)                    y = a;
    else if (sum == '0 || ex <= EZERO)  y = '0;
    else if (ex >= EINF)                y = {sl, EMAX, {SWIDTH{1'b0}}};
    else                                y = {sl, ex[EWIDTH-1:0], frac};
  end
endmodule

module flp_accum #(
  parameter int EWIDTH  = 8,
  parameter int SWIDTH  = 23,
  parameter int RSWIDTH = 2,
  parameter int CWIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [EWIDTH+SWIDTH:0]   i_data,
  input  logic                     i_last,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic [EWIDTH+SWIDTH:0]   o_data,
  output logic [CWIDTH-1:0]        o_count,
  input  logic                     i_ready
);
  // Handshake: a beat transfers on a rising edge where valid and ready are both
  // high; o_ready/o_valid come straight from registers, never from i_valid/i_ready.
  localparam int FWIDTH = 1 + EWIDTH + SWIDTH;

  typedef enum logic {ACC, OUT} state_t;
  state_t state;

  logic [FWIDTH-1:0] acc, sum;
  logic [CWIDTH-1:0] count;

  flp_add_test #(.EWIDTH(EWIDTH), .SWIDTH(SWIDTH), .RSWIDTH(RSWIDTH)) u_add (
    .a(acc),
    .b(i_data),
    .y(sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ACC;
      acc     <= '0;
      count   <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      case (state)
        ACC: if (i_valid) begin
          acc <= sum;
          if (count != '1) count <= count + CWIDTH'(1);
          if (i_last) begin
            state   <= OUT;
            o_ready <= 1'b0;
            o_valid <= 1'b1;
          end
        end
        OUT: if (i_ready) begin
          state   <= ACC;
          acc     <= '0;
          count   <= '0;
          o_ready <= 1'b1;
          o_valid <= 1'b0;
        end
        default: state <= ACC;
      endcase
    end
  end

  assign o_data  = acc;
  assign o_count = count;
endmodule

// File: tb/tb_flp_accum.sv
// Directed bench for flp_accum: sums, holds under backpressure, back-to-back vectors,
// special values, mid-vector reset and counter saturation on a narrow-counter copy.

module tb_flp_accum;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_last = 1'b0;
  logic        i_ready = 1'b0;
  logic        o_ready, o_valid, o_ready2, o_valid2;
  logic [31:0] o_data, o_data2;
  logic [15:0] o_count;
  logic [1:0]  o_count2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flp_accum dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .o_count(o_count),
    .i_ready(i_ready)
  );

  flp_accum #(.CWIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
    .o_ready(o_ready2), .o_valid(o_valid2), .o_data(o_data2), .o_count(o_count2),
    .i_ready(i_ready)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_valid = 1'b0; i_last = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    i_valid = 1'b1; i_data = d; i_last = last;
    tick();
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic test_reset();
    i_ready = 1'b0;
    do_reset();
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", o_valid); end
    checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 00000000", o_data); end
    checks++; if (o_count !== 16'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", o_count); end
  endtask

  task automatic test_sum3();
    i_ready = 1'b1;
    beat(32'h3F800000, 1'b0);
    beat(32'h40000000, 1'b0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL sum3_early_valid got %b exp 0", o_valid); end
    beat(32'h40400000, 1'b1);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL sum3_valid got %b exp 1", o_valid); end
    checks++; if (o_data !== 32'h40C00000) begin errors++; $display("FAIL sum3_data got %h exp 40c00000", o_data); end
    checks++; if (o_count !== 16'd3) begin errors++; $display("FAIL sum3_count got %0d exp 3", o_count); end
    tick();
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL sum3_release got v%b r%b exp v0 r1", o_valid, o_ready); end
    checks++; if (o_data !== 32'h0 || o_count !== 16'd0) begin errors++; $display("FAIL sum3_clear got %h/%0d exp 00000000/0", o_data, o_count); end
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    beat(32'h3F800000, 1'b0);
    beat(32'h40000000, 1'b0);
    beat(32'h40400000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1; i_data = 32'h3F800000 + $urandom_range(0, 255); i_last = k[0];
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_data !== 32'h40C00000 || o_count !== 16'd3) begin
        errors++;
        $display("FAIL hold_%0d got v%b r%b %h/%0d exp v1 r0 40c00000/3", k, o_valid, o_ready, o_data, o_count);
      end
    end
    i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b0 || o_count !== 16'd0) begin errors++; $display("FAIL hold_release got v%b %0d exp v0 0", o_valid, o_count); end
    beat(32'h3F800000, 1'b1);
    checks++; if (o_data !== 32'h3F800000 || o_count !== 16'd1) begin errors++; $display("FAIL hold_after got %h/%0d exp 3f800000/1", o_data, o_count); end
    tick();
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b1;
    beat(32'h3F800000, 1'b1);
    checks++; if (o_data !== 32'h3F800000 || o_count !== 16'd1) begin errors++; $display("FAIL b2b_first got %h/%0d exp 3f800000/1", o_data, o_count); end
    tick();
    beat(32'h40000000, 1'b1);
    checks++; if (o_data !== 32'h40000000 || o_count !== 16'd1) begin errors++; $display("FAIL b2b_second got %h/%0d exp 40000000/1", o_data, o_count); end
    tick();
  endtask

  task automatic test_signs();
    i_ready = 1'b1;
    beat(32'h40400000, 1'b0);
    beat(32'hBF800000, 1'b1);
    checks++; if (o_data !== 32'h40000000) begin errors++; $display("FAIL sub_data got %h exp 40000000", o_data); end
    tick();
    beat(32'h3F800000, 1'b0);
    beat(32'hBF800000, 1'b1);
    checks++; if (o_data !== 32'h00000000) begin errors++; $display("FAIL cancel_data got %h exp 00000000", o_data); end
    tick();
    beat(32'h80000000, 1'b1);
    checks++; if (o_data !== 32'h00000000) begin errors++; $display("FAIL negzero_data got %h exp 00000000", o_data); end
    tick();
  endtask

  task automatic test_special();
    i_ready = 1'b1;
    beat(32'h7F800000, 1'b0);
    beat(32'hFF800000, 1'b1);
    checks++;
    if (o_data[30:23] !== 8'hFF || o_data[22:0] === 23'h0) begin
      errors++; $display("FAIL nan_data got %h exp exponent ff, significand nonzero", o_data);
    end
    tick();
    beat(32'h7F7FFFFF, 1'b0);
    beat(32'h7F7FFFFF, 1'b1);
    checks++; if (o_data !== 32'h7F800000) begin errors++; $display("FAIL ovf_data got %h exp 7f800000", o_data); end
    tick();
  endtask

  task automatic test_mid_reset();
    i_ready = 1'b1;
    beat(32'h3F800000, 1'b0);
    beat(32'h40000000, 1'b0);
    do_reset();
    checks++; if (o_count !== 16'd0 || o_data !== 32'h0) begin errors++; $display("FAIL midrst_clear got %h/%0d exp 00000000/0", o_data, o_count); end
    beat(32'h40400000, 1'b1);
    checks++; if (o_data !== 32'h40400000 || o_count !== 16'd1) begin errors++; $display("FAIL midrst_data got %h/%0d exp 40400000/1", o_data, o_count); end
    tick();
  endtask

  task automatic test_saturate();
    i_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) beat(32'h3F800000, k == 4);
    checks++; if (o_count2 !== 2'd3) begin errors++; $display("FAIL sat_count got %0d exp 3", o_count2); end
    checks++; if (o_data2 !== 32'h40A00000) begin errors++; $display("FAIL sat_data got %h exp 40a00000", o_data2); end
    checks++; if (o_count !== 16'd5 || o_valid2 !== 1'b1) begin errors++; $display("FAIL sat_wide got %0d v%b exp 5 v1", o_count, o_valid2); end
    i_ready = 1'b1;
    tick();
    checks++; if (o_count2 !== 2'd0 || o_ready2 !== 1'b1) begin errors++; $display("FAIL sat_clear got %0d r%b exp 0 r1", o_count2, o_ready2); end
  endtask

  initial begin
    test_reset();
    test_sum3();
    test_backpressure();
    test_back_to_back();
    test_signs();
    test_special();
    test_mid_reset();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
